// File: rtl/div_scheduler.sv
// div_scheduler: shares one iterative divider between the two issue slots.
//
// Slot A (older) and slot B (younger) may both present a div/rem request in
// the same cycle. A goes to the divider first and B waits in a one-entry
// pending register. Results come back tagged with the destination register
// and the originating slot. The issue stage is frozen with stall_out until
// every accepted request has been written back.
//
// Optional build macro DIV_SCHED_EARLY_OUT_EN: divide-by-zero and unsigned
// src1<src2 requests accepted from IDLE skip the divider. Their result is
// presented the cycle after accept.
//
// Ports:
//   clk, rst (async, active-high)    clock / reset
//   flush                            abort everything, highest priority
//   stall_in                         writeback not ready, hold the result
//   req_valid[1]/[0]                 slot A / slot B request
//   req_op_*                         {signed, want_remainder}
//   req_src1_*, req_src2_*, req_rd_* dividend, divisor, destination
//   div_start/div_op/div_x/div_y     launch interface to the divider
//   div_cancel                       one-cycle abort to the divider
//   div_done/div_result              divider completion
//   res_valid/res_data/res_rd/res_slot  tagged result (slot 1=A, 0=B)
//   stall_out                        freeze the issue stage
//   err_timeout                      sticky divider watchdog flag
module div_scheduler #(
  parameter int XLEN        = 32,
  parameter int DIV_MAX_CYC = 40
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            stall_in,
  input  logic [1:0]      req_valid,
  input  logic [1:0]      req_op_a,
  input  logic [1:0]      req_op_b,
  input  logic [XLEN-1:0] req_src1_a,
  input  logic [XLEN-1:0] req_src2_a,
  input  logic [XLEN-1:0] req_src1_b,
  input  logic [XLEN-1:0] req_src2_b,
  input  logic [4:0]      req_rd_a,
  input  logic [4:0]      req_rd_b,
  output logic            div_start,
  output logic [1:0]      div_op,
  output logic [XLEN-1:0] div_x,
  output logic [XLEN-1:0] div_y,
  output logic            div_cancel,
  input  logic            div_done,
  input  logic [XLEN-1:0] div_result,
  output logic            res_valid,
  output logic [XLEN-1:0] res_data,
  output logic [4:0]      res_rd,
  output logic            res_slot,
  output logic            stall_out,
  output logic            err_timeout
);

  localparam int CW = $clog2(DIV_MAX_CYC + 1);
  // The counter reads k in the k-th cycle after div_start. The flag is
  // therefore visible DIV_MAX_CYC cycles after the start pulse.
  localparam logic [CW-1:0] CNT_LIMIT = CW'(DIV_MAX_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          state_r;
  logic            pend_valid_r;
  logic [1:0]      pend_op_r;
  logic [XLEN-1:0] pend_x_r;
  logic [XLEN-1:0] pend_y_r;
  logic [4:0]      pend_rd_r;
  logic [CW-1:0]   cnt_r;
  logic            start_r;
  logic [1:0]      op_r;
  logic [XLEN-1:0] x_r;
  logic [XLEN-1:0] y_r;
  logic [4:0]      cur_rd_r;
  logic            cur_slot_r;
  logic            res_valid_r;
  logic [XLEN-1:0] res_data_r;
  logic [4:0]      res_rd_r;
  logic            res_slot_r;
  logic            cancel_r;
  logic            err_r;

  logic            accept_s;
  logic            launch_s;
  logic [1:0]      sel_op_s;
  logic [XLEN-1:0] sel_x_s;
  logic [XLEN-1:0] sel_y_s;
  logic [4:0]      sel_rd_s;
  logic            sel_slot_s;
  logic            early_s;
  logic [XLEN-1:0] early_res_s;

  // Request selection: A wins whenever it is present, B only when alone.
  always_comb begin
    accept_s = (state_r == S_IDLE) && !pend_valid_r && !flush && (req_valid != 2'b00);
    if (req_valid[1]) begin
      sel_op_s   = req_op_a;
      sel_x_s    = req_src1_a;
      sel_y_s    = req_src2_a;
      sel_rd_s   = req_rd_a;
      sel_slot_s = 1'b1;
    end else begin
      sel_op_s   = req_op_b;
      sel_x_s    = req_src1_b;
      sel_y_s    = req_src2_b;
      sel_rd_s   = req_rd_b;
      sel_slot_s = 1'b0;
    end
  end

`ifdef DIV_SCHED_EARLY_OUT_EN
  // Early-out decode: results known without iterating the divider.
  always_comb begin
    early_s     = 1'b0;
    early_res_s = {XLEN{1'b0}};
    if (sel_y_s == {XLEN{1'b0}}) begin
      early_s     = 1'b1;
      early_res_s = sel_op_s[0] ? sel_x_s : {XLEN{1'b1}};
    end else if (!sel_op_s[1] && (sel_x_s < sel_y_s)) begin
      early_s     = 1'b1;
      early_res_s = sel_op_s[0] ? sel_x_s : {XLEN{1'b0}};
    end else begin
      early_s     = 1'b0;
      early_res_s = {XLEN{1'b0}};
    end
  end
`else
  assign early_s     = 1'b0;
  assign early_res_s = {XLEN{1'b0}};
`endif

  assign launch_s = accept_s && !early_s;

  // The accept-cycle launch bypasses the operand registers so the divider
  // starts in the same cycle the request is sampled.
  assign div_start   = launch_s | start_r;
  assign div_op      = launch_s ? sel_op_s : op_r;
  assign div_x       = launch_s ? sel_x_s  : x_r;
  assign div_y       = launch_s ? sel_y_s  : y_r;
  assign div_cancel  = cancel_r;
  assign res_valid   = res_valid_r;
  assign res_data    = res_data_r;
  assign res_rd      = res_rd_r;
  assign res_slot    = res_slot_r;
  assign err_timeout = err_r;
  // Includes the accept cycle itself so the next bundle is held back.
  assign stall_out   = (state_r != S_IDLE) | pend_valid_r | accept_s;

  // Scheduler FSM: acceptance, divider tracking, result hold and watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      pend_valid_r <= 1'b0;
      pend_op_r    <= 2'b00;
      pend_x_r     <= {XLEN{1'b0}};
      pend_y_r     <= {XLEN{1'b0}};
      pend_rd_r    <= 5'd0;
      cnt_r        <= {CW{1'b0}};
      start_r      <= 1'b0;
      op_r         <= 2'b00;
      x_r          <= {XLEN{1'b0}};
      y_r          <= {XLEN{1'b0}};
      cur_rd_r     <= 5'd0;
      cur_slot_r   <= 1'b0;
      res_valid_r  <= 1'b0;
      res_data_r   <= {XLEN{1'b0}};
      res_rd_r     <= 5'd0;
      res_slot_r   <= 1'b0;
      cancel_r     <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      start_r  <= 1'b0;
      cancel_r <= 1'b0;
      if (flush) begin
        cancel_r     <= (state_r == S_RUN);
        state_r      <= S_IDLE;
        pend_valid_r <= 1'b0;
        res_valid_r  <= 1'b0;
      end else begin
        case (state_r)
          S_IDLE: begin
            if (accept_s) begin
              op_r       <= sel_op_s;
              x_r        <= sel_x_s;
              y_r        <= sel_y_s;
              cur_rd_r   <= sel_rd_s;
              cur_slot_r <= sel_slot_s;
              if (req_valid == 2'b11) begin
                pend_valid_r <= 1'b1;
                pend_op_r    <= req_op_b;
                pend_x_r     <= req_src1_b;
                pend_y_r     <= req_src2_b;
                pend_rd_r    <= req_rd_b;
              end
              if (early_s) begin
                state_r     <= S_HOLD;
                res_valid_r <= 1'b1;
                res_data_r  <= early_res_s;
                res_rd_r    <= sel_rd_s;
                res_slot_r  <= sel_slot_s;
              end else begin
                state_r <= S_RUN;
                // The accept cycle already counts as divider cycle zero.
                cnt_r   <= CW'(1);
              end
            end
          end
          S_RUN: begin
            if (div_done) begin
              state_r     <= S_HOLD;
              res_valid_r <= 1'b1;
              res_data_r  <= div_result;
              res_rd_r    <= cur_rd_r;
              res_slot_r  <= cur_slot_r;
            end else if (cnt_r >= CNT_LIMIT) begin
              err_r        <= 1'b1;
              cancel_r     <= 1'b1;
              state_r      <= S_IDLE;
              pend_valid_r <= 1'b0;
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
          S_HOLD: begin
            if (!stall_in) begin
              res_valid_r <= 1'b0;
              if (pend_valid_r) begin
                // Pending B always takes the divider path.
                state_r      <= S_RUN;
                start_r      <= 1'b1;
                op_r         <= pend_op_r;
                x_r          <= pend_x_r;
                y_r          <= pend_y_r;
                cur_rd_r     <= pend_rd_r;
                cur_slot_r   <= 1'b0;
                pend_valid_r <= 1'b0;
                cnt_r        <= {CW{1'b0}};
              end else begin
                state_r <= S_IDLE;
              end
            end
          end
          default: begin
            state_r <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_scheduler.sv
// Self-checking bench for div_scheduler: reset state, a table of single
// requests, hand-timed multi-cycle sequences, and a randomized run scored
// against an arithmetic reference model of the divider.
module tb_div_scheduler;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        stall_in;
  logic [1:0]  req_valid;
  logic [1:0]  req_op_a, req_op_b;
  logic [31:0] req_src1_a, req_src2_a, req_src1_b, req_src2_b;
  logic [4:0]  req_rd_a, req_rd_b;
  logic        div_start;
  logic [1:0]  div_op;
  logic [31:0] div_x, div_y;
  logic        div_cancel;
  logic        div_done;
  logic [31:0] div_result;
  logic        res_valid;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic        res_slot;
  logic        stall_out;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  div_scheduler #(.XLEN(32), .DIV_MAX_CYC(40)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_in(stall_in),
    .req_valid(req_valid), .req_op_a(req_op_a), .req_op_b(req_op_b),
    .req_src1_a(req_src1_a), .req_src2_a(req_src2_a),
    .req_src1_b(req_src1_b), .req_src2_b(req_src2_b),
    .req_rd_a(req_rd_a), .req_rd_b(req_rd_b),
    .div_start(div_start), .div_op(div_op), .div_x(div_x), .div_y(div_y),
    .div_cancel(div_cancel), .div_done(div_done), .div_result(div_result),
    .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd),
    .res_slot(res_slot), .stall_out(stall_out), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic: quotient/remainder with div-by-zero and overflow rules.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] x,
                                          input logic [31:0] y);
    logic signed [31:0] sx;
    logic signed [31:0] sy;
    sx = x;
    sy = y;
    if (y == 32'd0) return op[0] ? x : 32'hFFFF_FFFF;
    if (!op[1]) return op[0] ? (x % y) : (x / y);
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return op[0] ? 32'd0 : x;
    return op[0] ? 32'(sx % sy) : 32'(sx / sy);
  endfunction

  // Divider model: done exactly bfm_lat cycles after the start pulse.
  int          fixed_lat = 5;
  logic        bfm_hang = 1'b0;
  logic        extra_done = 1'b0;
  logic        bfm_busy;
  int          bfm_cnt, bfm_lat;
  logic [1:0]  bfm_op;
  logic [31:0] bfm_x, bfm_y;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bfm_busy <= 1'b0;
      bfm_cnt  <= 0;
      bfm_lat  <= 1;
      bfm_op   <= 2'b00;
      bfm_x    <= 32'd0;
      bfm_y    <= 32'd0;
    end else if (div_cancel) begin
      bfm_busy <= 1'b0;
    end else if (div_start) begin
      bfm_busy <= 1'b1;
      bfm_cnt  <= 1;
      bfm_lat  <= (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 8));
      bfm_op   <= div_op;
      bfm_x    <= div_x;
      bfm_y    <= div_y;
    end else if (bfm_busy) begin
      if (bfm_cnt == bfm_lat && !bfm_hang) bfm_busy <= 1'b0;
      else bfm_cnt <= bfm_cnt + 1;
    end
  end

  assign div_done   = (bfm_busy && !bfm_hang && bfm_cnt == bfm_lat) || extra_done;
  assign div_result = ref_div(bfm_op, bfm_x, bfm_y);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next cycle; one-shot inputs drop back to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    req_valid  = 2'b00;
    flush      = 1'b0;
    extra_done = 1'b0;
    #1;
  endtask

  task automatic drive_req(input logic [1:0] rv,
                           input logic [1:0] opa, input logic [31:0] xa, input logic [31:0] ya,
                           input logic [4:0] rda,
                           input logic [1:0] opb, input logic [31:0] xb, input logic [31:0] yb,
                           input logic [4:0] rdb);
    req_valid  = rv;
    req_op_a   = opa;  req_src1_a = xa;  req_src2_a = ya;  req_rd_a = rda;
    req_op_b   = opb;  req_src1_b = xb;  req_src2_b = yb;  req_rd_b = rdb;
    #1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    int          lat;
    bit          use_b;
    bit          eo;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        slot;
  } exp_t;

  vec_t vecs[12];
  exp_t exp_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int lat_seen;
    int exp_lat;
    int issued;
    int cyc;
    exp_t e;

    vecs[0]  = '{2'b00, 32'd100,        32'd7,          5, 1'b0, 1'b0, 32'd14};
    vecs[1]  = '{2'b01, 32'd100,        32'd7,          3, 1'b1, 1'b0, 32'd2};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF7,  32'd2,          6, 1'b0, 1'b0, 32'hFFFF_FFFC};
    vecs[3]  = '{2'b11, 32'hFFFF_FFF7,  32'd2,          2, 1'b1, 1'b0, 32'hFFFF_FFFF};
    vecs[4]  = '{2'b00, 32'd5,          32'd0,          4, 1'b0, 1'b1, 32'hFFFF_FFFF};
    vecs[5]  = '{2'b01, 32'd5,          32'd0,          4, 1'b1, 1'b1, 32'd5};
    vecs[6]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  7, 1'b0, 1'b0, 32'h8000_0000};
    vecs[7]  = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  1, 1'b1, 1'b0, 32'd0};
    vecs[8]  = '{2'b00, 32'd7,          32'd100,        3, 1'b0, 1'b1, 32'd0};
    vecs[9]  = '{2'b01, 32'd7,          32'd100,        3, 1'b1, 1'b1, 32'd7};
    vecs[10] = '{2'b10, 32'd7,          32'd100,        3, 1'b0, 1'b0, 32'd0};
    vecs[11] = '{2'b10, 32'hFFFF_FFF7,  32'd0,          2, 1'b1, 1'b1, 32'hFFFF_FFFF};

    rst = 1'b1; flush = 1'b0; stall_in = 1'b0; extra_done = 1'b0;
    drive_req(2'b00, 2'b00, 32'd0, 32'd0, 5'd0, 2'b00, 32'd0, 32'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", res_valid, 32'd0);
    chk("rst_stall_out", stall_out, 32'd0);
    chk("rst_div_start", div_start, 32'd0);
    chk("rst_div_cancel", div_cancel, 32'd0);
    chk("rst_err", err_timeout, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table of single requests from either slot.
    for (int i = 0; i < 12; i++) begin
      fixed_lat = vecs[i].lat;
      tick();
      if (vecs[i].use_b)
        drive_req(2'b01, 2'b00, 32'd0, 32'd0, 5'd0, vecs[i].op, vecs[i].x, vecs[i].y, 5'(i + 1));
      else
        drive_req(2'b10, vecs[i].op, vecs[i].x, vecs[i].y, 5'(i + 1), 2'b00, 32'd0, 32'd0, 5'd0);
      chk("tbl_stall_accept", stall_out, 32'd1);
      lat_seen = 0;
      for (int c = 1; c <= 80 && lat_seen == 0; c++) begin
        tick();
        if (res_valid) lat_seen = c;
      end
      exp_lat = vecs[i].lat + 1;
`ifdef DIV_SCHED_EARLY_OUT_EN
      if (vecs[i].eo) exp_lat = 1;
`endif
      chk("tbl_latency", lat_seen, exp_lat);
      chk("tbl_data", res_data, vecs[i].exp);
      chk("tbl_rd", res_rd, 32'(i + 1));
      chk("tbl_slot", res_slot, vecs[i].use_b ? 32'd0 : 32'd1);
      tick();
      chk("tbl_release", stall_out, 32'd0);
    end

    // Single A, unsigned 100/7, divider done after 33 cycles.
    fixed_lat = 33;
    tick();
    drive_req(2'b10, 2'b00, 32'd100, 32'd7, 5'd9, 2'b00, 32'd0, 32'd0, 5'd0);
    chk("t1_start", div_start, 32'd1);
    chk("t1_x", div_x, 32'd100);
    chk("t1_y", div_y, 32'd7);
    chk("t1_stall0", stall_out, 32'd1);
    for (int c = 1; c <= 33; c++) begin
      tick();
      chk("t1_busy_stall", stall_out, 32'd1);
      chk("t1_no_res", res_valid, 32'd0);
      chk("t1_no_start", div_start, 32'd0);
      chk("t1_x_held", div_x, 32'd100);
    end
    tick();
    chk("t1_res_valid", res_valid, 32'd1);
    chk("t1_res_data", res_data, 32'd14);
    chk("t1_res_slot", res_slot, 32'd1);
    chk("t1_res_rd", res_rd, 32'd9);
    chk("t1_stall34", stall_out, 32'd1);
    tick();
    chk("t1_res_drop", res_valid, 32'd0);
    chk("t1_release", stall_out, 32'd0);

    // Dual request: A = 100%7 unsigned, B = -9/2 signed.
    fixed_lat = 4;
    tick();
    drive_req(2'b11, 2'b01, 32'd100, 32'd7, 5'd3, 2'b10, 32'hFFFF_FFF7, 32'd2, 5'd5);
    chk("t2_start_a", div_start, 32'd1);
    chk("t2_x_a", div_x, 32'd100);
    for (int c = 1; c <= 4; c++) tick();
    tick();
    chk("t2_res_a_valid", res_valid, 32'd1);
    chk("t2_res_a_data", res_data, 32'd2);
    chk("t2_res_a_slot", res_slot, 32'd1);
    chk("t2_res_a_rd", res_rd, 32'd3);
    chk("t2_no_start_b_yet", div_start, 32'd0);
    tick();
    chk("t2_start_b", div_start, 32'd1);
    chk("t2_x_b", div_x, 32'hFFFF_FFF7);
    chk("t2_y_b", div_y, 32'd2);
    chk("t2_op_b", div_op, 32'd2);
    chk("t2_res_gap", res_valid, 32'd0);
    chk("t2_stall_b", stall_out, 32'd1);
    for (int c = 1; c <= 4; c++) tick();
    tick();
    chk("t2_res_b_valid", res_valid, 32'd1);
    chk("t2_res_b_data", res_data, 32'hFFFF_FFFC);
    chk("t2_res_b_slot", res_slot, 32'd0);
    chk("t2_res_b_rd", res_rd, 32'd5);
    tick();
    chk("t2_release", stall_out, 32'd0);

    // Writeback stalled across A's completion: result held, B waits.
    fixed_lat = 3;
    stall_in = 1'b1;
    tick();
    drive_req(2'b11, 2'b01, 32'd100, 32'd7, 5'd3, 2'b10, 32'hFFFF_FFF7, 32'd2, 5'd5);
    for (int c = 1; c <= 3; c++) tick();
    for (int c = 4; c <= 8; c++) begin
      tick();
      chk("t3_hold_valid", res_valid, 32'd1);
      chk("t3_hold_data", res_data, 32'd2);
      chk("t3_hold_no_start", div_start, 32'd0);
    end
    tick();
    stall_in = 1'b0;
    #1;
    chk("t3_last_valid", res_valid, 32'd1);
    tick();
    chk("t3_start_b", div_start, 32'd1);
    chk("t3_res_drop", res_valid, 32'd0);
    for (int c = 1; c <= 3; c++) tick();
    tick();
    chk("t3_res_b", res_data, 32'hFFFF_FFFC);
    chk("t3_res_b_valid", res_valid, 32'd1);
    tick();

    // Flush 10 cycles into RUN with B pending, then a stale completion.
    fixed_lat = 30;
    tick();
    drive_req(2'b11, 2'b00, 32'd100, 32'd7, 5'd1, 2'b00, 32'd50, 32'd3, 5'd2);
    for (int c = 1; c <= 10; c++) tick();
    flush = 1'b1;
    #1;
    tick();
    chk("t4_cancel", div_cancel, 32'd1);
    chk("t4_stall_free", stall_out, 32'd0);
    chk("t4_no_res", res_valid, 32'd0);
    tick();
    extra_done = 1'b1;
    #1;
    chk("t4_late_done_stall", stall_out, 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t4_late_no_res", res_valid, 32'd0);
      chk("t4_cancel_once", div_cancel, 32'd0);
      chk("t4_no_start", div_start, 32'd0);
    end
    // A request presented together with flush is ignored.
    drive_req(2'b10, 2'b00, 32'd9, 32'd3, 5'd4, 2'b00, 32'd0, 32'd0, 5'd0);
    flush = 1'b1;
    #1;
    chk("t4_flush_req_start", div_start, 32'd0);
    chk("t4_flush_req_stall", stall_out, 32'd0);
    tick();
    chk("t4_flush_req_idle", stall_out, 32'd0);
    tick();
    chk("t4_flush_req_nores", res_valid, 32'd0);

`ifdef DIV_SCHED_EARLY_OUT_EN
    // Early-out: unsigned 5/0 never touches the divider.
    tick();
    drive_req(2'b10, 2'b00, 32'd5, 32'd0, 5'd6, 2'b00, 32'd0, 32'd0, 5'd0);
    chk("eo_no_start", div_start, 32'd0);
    chk("eo_stall", stall_out, 32'd1);
    tick();
    chk("eo_valid", res_valid, 32'd1);
    chk("eo_data", res_data, 32'hFFFF_FFFF);
    chk("eo_no_start1", div_start, 32'd0);
    tick();
    chk("eo_release", stall_out, 32'd0);
    // Early A, pending B still uses the divider.
    fixed_lat = 2;
    tick();
    drive_req(2'b11, 2'b00, 32'd7, 32'd100, 5'd1, 2'b00, 32'd100, 32'd7, 5'd2);
    tick();
    chk("eo2_a_data", res_data, 32'd0);
    chk("eo2_a_valid", res_valid, 32'd1);
    tick();
    chk("eo2_b_start", div_start, 32'd1);
    for (int c = 1; c <= 2; c++) tick();
    tick();
    chk("eo2_b_data", res_data, 32'd14);
    chk("eo2_b_slot", res_slot, 32'd0);
    tick();
`endif

    // Randomized traffic scored against the arithmetic model.
    fixed_lat = 0;
    issued = 0;
    cyc = 0;
    while ((issued < 120 || exp_q.size() != 0) && cyc < 20000) begin
      logic [1:0]  rv, opa, opb;
      logic [31:0] xa, ya, xb, yb;
      logic [4:0]  rda, rdb;
      cyc++;
      tick();
      stall_in = ($urandom_range(0, 3) == 0);
      #1;
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected_res", res_valid, 32'd0);
        end else begin
          chk("rnd_data", res_data, exp_q[0].data);
          chk("rnd_rd", res_rd, exp_q[0].rd);
          chk("rnd_slot", res_slot, exp_q[0].slot);
          if (!stall_in) void'(exp_q.pop_front());
        end
      end else if (issued < 120 && exp_q.size() == 0 && !stall_out) begin
        rv  = 2'($urandom_range(1, 3));
        opa = 2'($urandom_range(0, 3));
        opb = 2'($urandom_range(0, 3));
        xa  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
        xb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
        ya  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
        yb  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
        rda = 5'($urandom);
        rdb = 5'($urandom);
        drive_req(rv, opa, xa, ya, rda, opb, xb, yb, rdb);
        chk("rnd_accept_stall", stall_out, 32'd1);
        if (rv[1]) begin
          e.data = ref_div(opa, xa, ya); e.rd = rda; e.slot = 1'b1;
          exp_q.push_back(e);
        end
        if (rv[0]) begin
          e.data = ref_div(opb, xb, yb); e.rd = rdb; e.slot = 1'b0;
          exp_q.push_back(e);
        end
        issued++;
      end
    end
    chk("rnd_all_issued", issued, 32'd120);
    chk("rnd_all_retired", exp_q.size(), 32'd0);
    stall_in = 1'b0;
    tick();
    tick();

    // Divider never completes: watchdog fires, pending B is dropped.
    bfm_hang = 1'b1;
    fixed_lat = 5;
    tick();
    drive_req(2'b11, 2'b00, 32'd100, 32'd7, 5'd1, 2'b00, 32'd8, 32'd2, 5'd2);
    for (int c = 1; c <= 39; c++) begin
      tick();
      chk("t5_no_err_yet", err_timeout, 32'd0);
      chk("t5_stall", stall_out, 32'd1);
    end
    tick();
    chk("t5_err", err_timeout, 32'd1);
    chk("t5_cancel", div_cancel, 32'd1);
    chk("t5_release", stall_out, 32'd0);
    chk("t5_no_res", res_valid, 32'd0);
    bfm_hang = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t5_no_b_start", div_start, 32'd0);
      chk("t5_no_res_after", res_valid, 32'd0);
      chk("t5_cancel_once", div_cancel, 32'd0);
      chk("t5_sticky", err_timeout, 32'd1);
    end
    // Flag survives a normal transaction and clears only on reset.
    fixed_lat = 2;
    drive_req(2'b10, 2'b00, 32'd100, 32'd7, 5'd1, 2'b00, 32'd0, 32'd0, 5'd0);
    for (int c = 0; c < 4; c++) tick();
    chk("t5_sticky_after_op", err_timeout, 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_clears_err", err_timeout, 32'd0);
    chk("t5_rst_stall", stall_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
